// File: rtl/enc_pkg.sv
// Shared types for the registered 8-to-3 priority encoder.
// The result struct travels from the combinational encoder into the output register.
package enc_pkg;

  localparam int unsigned ENC_IN_W  = 8;
  localparam int unsigned ENC_OUT_W = 3;

  typedef logic [ENC_IN_W-1:0]  enc_onehot_t;
  typedef logic [ENC_OUT_W-1:0] enc_code_t;

  typedef struct packed {
    enc_code_t code;
    logic      zero;
    logic      multi;
  } enc_result_t;

  typedef enum logic {
    StEmpty,
    StFull
  } enc_state_e;

endpackage

// File: rtl/enc8x3_prio_comb.sv
// Purely combinational priority encode (bit 7 wins) with all-zero and multi-hot flags.
module enc8x3_prio_comb
  import enc_pkg::*;
(
  input  enc_onehot_t y,
  output enc_result_t res
);

  logic seen;

  always_comb begin
    res  = '0;
    seen = 1'b0;
    // Ascending scan: the last set bit is the highest, any earlier hit marks multi-hot.
    for (int i = 0; i < ENC_IN_W; i++) begin
      if (y[i]) begin
        res.code  = enc_code_t'(i);
        res.multi = res.multi | seen;
        seen      = 1'b1;
      end
    end
    res.zero = ~|y;
  end

endmodule

// File: rtl/encoder_8x3_reg.sv
// Registered 8-to-3 priority encoder: one output register stage with valid/ready
// handshakes and a saturating count of malformed accepted words.
module encoder_8x3_reg
  import enc_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_code,
  output logic                 out_zero,
  output logic                 out_multi,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] CntMax = '1;

  enc_state_e           state_q, state_d;
  enc_result_t          res_comb, res_q;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 accept;

  enc8x3_prio_comb u_prio (
    .y   (in_y),
    .res (res_comb)
  );

  assign out_valid = (state_q == StFull);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull: begin
        if (accept)         state_d = StFull;
        else if (out_ready) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    err_d = err_q;
    // Clear takes priority over a coincident malformed accept.
    if (err_clr) begin
      err_d = '0;
    end else if (accept && (res_comb.zero || res_comb.multi) && (err_q != CntMax)) begin
      err_d = err_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      res_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      // Loading only on accept keeps in_y (even X) out of the register when idle.
      if (accept) res_q <= res_comb;
    end
  end

  assign out_code  = res_q.code;
  assign out_zero  = res_q.zero;
  assign out_multi = res_q.multi;
  assign err_count = err_q;

endmodule

// File: tb/tb_encoder_8x3_reg.sv
// Scoreboard bench for encoder_8x3_reg: expectations are queued on accept and
// compared while the DUT presents them.
module tb_encoder_8x3_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, err_clr;
  logic [7:0] in_y;
  logic       in_ready, out_valid, out_zero, out_multi;
  logic [2:0] out_code;
  logic [7:0] err_count;

  logic       s_in_valid, s_out_ready, s_err_clr;
  logic [7:0] s_in_y;
  logic       s_in_ready, s_out_valid, s_out_zero, s_out_multi;
  logic [2:0] s_out_code;
  logic [1:0] s_err_count;

  typedef struct packed {
    logic [2:0] code;
    logic       zero;
    logic       multi;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  encoder_8x3_reg #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_zero  (out_zero),
    .out_multi (out_multi),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  encoder_8x3_reg #(.ERR_CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_y      (s_in_y),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_code  (s_out_code),
    .out_zero  (s_out_zero),
    .out_multi (s_out_multi),
    .err_clr   (s_err_clr),
    .err_count (s_err_count)
  );

  // Reference: highest set bit by top-down search, multi from popcount.
  function automatic exp_t model(input logic [7:0] y);
    exp_t r;
    r.code  = 3'd0;
    r.zero  = (y == 8'h00);
    r.multi = ($countones(y) >= 2);
    for (int i = 7; i >= 0; i--) begin
      if (y[i]) begin
        r.code = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  // Advance one clock; the scoreboard tracks which handshakes complete at this edge.
  task automatic tick();
    #1;
    if (!rst && out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    if (!rst && in_valid && in_ready) q.push_back(model(in_y));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0; in_y = 8'h00;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_err_clr = 1'b0; s_in_y = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    e = '0;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_valid got=%b want=0", out_valid); nmis++;
    end
    nvec++;
    if ({out_code, out_zero, out_multi} !== e) begin
      $display("FAIL reset_fields got=%b want=%b", {out_code, out_zero, out_multi}, e); nmis++;
    end
    nvec++;
    if (err_count !== 8'd0) begin
      $display("FAIL reset_err got=%0d want=0", err_count); nmis++;
    end
    nvec++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_onehot();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_y     = 8'h01 << i;
      tick();
      e = (q.size() > 0) ? q[0] : '1;
      if (out_valid !== 1'b1 || {out_code, out_zero, out_multi} !== e || out_code !== 3'(i)) begin
        $display("FAIL onehot_%0d got=v%b %b want=%b code=%0d", i, out_valid,
                 {out_code, out_zero, out_multi}, e, i);
        nmis++;
      end
      nvec++;
    end
    in_valid = 1'b0;
    tick();
    if (out_valid !== 1'b0 || err_count !== 8'd0) begin
      $display("FAIL onehot_drain got=v%b err=%0d want=v0 err=0", out_valid, err_count); nmis++;
    end
    nvec++;
  endtask

  task automatic test_roundtrip();
    exp_t       e;
    logic [2:0] abc;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      abc      = 3'(k);
      in_valid = 1'b1;
      in_y     = 8'b1 << abc;  // decoder_3x8 output for {a,b,c}
      tick();
      e = (q.size() > 0) ? q[0] : '1;
      if (out_valid !== 1'b1 || out_code !== abc || {out_code, out_zero, out_multi} !== e) begin
        $display("FAIL roundtrip_%0d got=v%b code=%0d want=code %0d", k, out_valid, out_code, abc);
        nmis++;
      end
      nvec++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_malformed();
    logic [7:0] words [3];
    exp_t       want  [3];
    exp_t       e;
    words[0] = 8'h00;       want[0] = '{code: 3'd0, zero: 1'b1, multi: 1'b0};
    words[1] = 8'b1010_0000; want[1] = '{code: 3'd7, zero: 1'b0, multi: 1'b1};
    words[2] = 8'hFF;       want[2] = '{code: 3'd7, zero: 1'b0, multi: 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_y     = words[k];
      tick();
      e = (q.size() > 0) ? q[0] : '1;
      if (out_valid !== 1'b1 || {out_code, out_zero, out_multi} !== want[k] || e !== want[k]) begin
        $display("FAIL malformed_%0d got=v%b %b want=%b", k, out_valid,
                 {out_code, out_zero, out_multi}, want[k]);
        nmis++;
      end
      nvec++;
    end
    in_valid = 1'b0;
    tick();
    if (err_count !== 8'd3) begin
      $display("FAIL malformed_err got=%0d want=3", err_count); nmis++;
    end
    nvec++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_y      = 8'h04;
    tick();
    out_ready = 1'b0;
    in_y      = 8'h10;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (in_ready !== 1'b0) begin
        $display("FAIL bp_ready_%0d got=%b want=0", k, in_ready); nmis++;
      end
      nvec++;
      tick();
      e = (q.size() > 0) ? q[0] : '1;
      if (out_valid !== 1'b1 || out_code !== 3'd2 || {out_code, out_zero, out_multi} !== e) begin
        $display("FAIL bp_hold_%0d got=v%b code=%0d want=v1 code=2", k, out_valid, out_code);
        nmis++;
      end
      nvec++;
    end
    out_ready = 1'b1;
    #1;
    if (in_ready !== 1'b1) begin
      $display("FAIL bp_release_ready got=%b want=1", in_ready); nmis++;
    end
    nvec++;
    tick();
    e = (q.size() > 0) ? q[0] : '1;
    if (out_valid !== 1'b1 || out_code !== 3'd4 || {out_code, out_zero, out_multi} !== e) begin
      $display("FAIL bp_next got=v%b code=%0d want=v1 code=4", out_valid, out_code); nmis++;
    end
    nvec++;
    // Idle with garbage on in_y must not disturb anything.
    in_valid = 1'b0;
    in_y     = 8'hxx;
    tick();
    tick();
    if (out_valid !== 1'b0 || $isunknown({out_code, out_zero, out_multi, err_count})) begin
      $display("FAIL idle_x got=v%b code=%b err=%b want=v0 known", out_valid, out_code, err_count);
      nmis++;
    end
    nvec++;
    in_y = 8'h00;
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_y      = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      tick();
      want = (k >= 3) ? 2'd3 : 2'(k);
      if (s_err_count !== want) begin
        $display("FAIL sat_%0d got=%0d want=%0d", k, s_err_count, want); nmis++;
      end
      nvec++;
    end
    s_err_clr = 1'b1;
    tick();
    if (s_err_count !== 2'd0) begin
      $display("FAIL sat_clr got=%0d want=0", s_err_count); nmis++;
    end
    nvec++;
    s_err_clr = 1'b0;
    tick();
    if (s_err_count !== 2'd1) begin
      $display("FAIL sat_after_clr got=%0d want=1", s_err_count); nmis++;
    end
    nvec++;
    s_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    exp_t e;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_y      = 8'h00;
    tick();
    in_y = 8'h20;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (out_valid !== 1'b1 || out_code !== 3'd5 || err_count === 8'd0) begin
      $display("FAIL ar_pre got=v%b code=%0d err=%0d want=v1 code=5 err>0", out_valid, out_code,
               err_count);
      nmis++;
    end
    nvec++;
    #2;
    rst = 1'b1;
    #1;
    if (out_valid !== 1'b0 || out_code !== 3'd0 || err_count !== 8'd0) begin
      $display("FAIL ar_now got=v%b code=%0d err=%0d want=0 0 0", out_valid, out_code, err_count);
      nmis++;
    end
    nvec++;
    q.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (out_valid !== 1'b0) begin
      $display("FAIL ar_post_empty got=%b want=0", out_valid); nmis++;
    end
    nvec++;
    in_valid = 1'b1;
    in_y     = 8'h02;
    tick();
    e = (q.size() > 0) ? q[0] : '1;
    if (out_valid !== 1'b1 || out_code !== 3'd1 || {out_code, out_zero, out_multi} !== e) begin
      $display("FAIL ar_first got=v%b code=%0d want=v1 code=1", out_valid, out_code); nmis++;
    end
    nvec++;
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_roundtrip();
    test_malformed();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/encoder_8x3_reg.md
Name: encoder_8x3_reg

Overview:
Registered 8-to-3 priority encoder with valid/ready handshakes. It is the inverse of the team's decoder_3x8: it takes an 8-bit one-hot word and returns the 3-bit index. It also flags malformed inputs (all-zero or multi-hot) and keeps a saturating error count. It sits between one-hot request/select sources and binary-index consumers, with one pipeline stage of latency.

Parameters:
ERR_CNT_W, 8, width of the saturating malformed-input counter (minimum 1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  in_y carries a word this cycle.
in_ready  output  1  block accepts the word this cycle.
in_y  input  8  one-hot input word. Bit i means index i.
out_valid  output  1  out_* fields hold a result.
out_ready  input  1  consumer takes the result this cycle.
out_code  output  3  encoded index. Bit 2 is MSB, same as the decoder's {a,b,c} ordering.
out_zero  output  1  accepted word was all-zero.
out_multi  output  1  accepted word had more than one bit set.
err_clr  input  1  synchronous clear of err_count.
err_count  output  ERR_CNT_W  saturating count of malformed accepted words.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values (asynchronous, immediate): out_valid=0, out_code=0, out_zero=0, out_multi=0, err_count=0.
- Reset mid-operation: any held result is discarded. No output handshake completes in the reset cycle.
- Output stage is a 2-state register:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational pass-through, no bubble).
  - Input accept: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- State transitions:
  - EMPTY + accept -> FULL, result loaded.
  - FULL + transfer, no accept -> EMPTY.
  - FULL + transfer + accept -> FULL, new result loaded the same cycle. Sustained throughput is 1 word per cycle.
  - FULL + !out_ready -> hold. in_ready=0 and all out_* fields stay stable.
- Latency: a word accepted at edge N is presented from edge N onward. The result is visible in the cycle after the accept cycle.
- Encoding:
  - out_code = index of the highest set bit of in_y (priority, bit 7 highest).
  - If in_y==0: out_code=0 and out_zero=1.
  - out_multi=1 when popcount(in_y) >= 2. out_code still reports the highest set bit.
  - out_zero and out_multi are never both 1.
- Error counter:
  - Increments by 1 on each accepted word with out_zero or out_multi set.
  - Saturates at 2^ERR_CNT_W-1 and does not wrap.
  - Not gated by out_ready.
- err_clr:
  - Sets err_count=0 at the next edge.
  - If err_clr coincides with an erroneous accept, clear wins and the result is 0.
- in_y is ignored when in_valid=0. X on in_y with in_valid=0 must not propagate into the outputs.

Decomposition:
- Shared package enc_pkg:
  - constants ENC_IN_W=8 and ENC_OUT_W=3;
  - typedef enc_onehot_t (logic [7:0]);
  - typedef enc_code_t (logic [2:0]);
  - typedef struct enc_result_t {code, zero, multi}.
- One sub-module, enc8x3_prio_comb: purely combinational priority encode plus zero/multi detect, returning an enc_result_t.
- encoder_8x3_reg holds the output register, the handshake and the counter.

Test Plan:
- Exhaustive one-hot with out_ready=1: in_y=8'b0000_0001..8'b1000_0000, one per cycle.
  -> out_code=0..7 one cycle later; out_zero=0, out_multi=0; err_count=0.
- Round-trip with decoder_3x8: drive {a,b,c}=000..111 and feed y into in_y.
  -> out_code equals {a,b,c} for all 8 values.
- Malformed words: in_y=8'h00, then 8'b1010_0000, then 8'hFF.
  -> out_code=0 with zero=1; then out_code=7 with multi=1; then out_code=7 with multi=1; err_count=3.
- Backpressure: accept 8'h04, hold out_ready=0 for 3 cycles while in_valid=1 with 8'h10.
  -> out_code stays 2 and in_ready=0 throughout. On out_ready=1, 2 transfers and 8'h10 is accepted that cycle; out_code=4 next cycle.
- Counter saturation and clear (ERR_CNT_W=2): 5 accepted in_y=8'h00.
  -> err_count=3 (holds). err_clr asserted together with a 6th 8'h00 -> err_count=0.
- Async reset mid-stream: assert rst between clock edges while FULL with out_code=5.
  -> out_valid and out_code drop to 0 immediately and err_count=0. After release, the first accept behaves as from EMPTY.
